// File: rtl/guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// guess_round_ctrl
// Round controller for the VGA guessing game. It walks one round through
// IDLE -> ARM -> CHECK -> WIN/MISS/LOSE -> DONE. A round allows several
// attempts, forces a LOSE when no answer arrives within a number of seg3
// ticks, keeps a saturating score of rounds won and reacts only to the rising
// edge of the debounced button.
//
// Ports
//   clk            system clock, all state updates on its rising edge
//   reset          asynchronous, active-low reset
//   seg3           one-cycle timebase tick, synchronous to clk
//   button         debounced button level (only its rising edge is used)
//   guess          1 = current guess is correct, sampled in CHECK
//   clr_score      synchronous score clear, honoured in every state
//   state          0 IDLE,1 ARM,2 CHECK,3 WIN,4 LOSE,5 DONE,6 MISS
//   score          rounds won, saturates at all-ones
//   attempts_left  guesses remaining in the current round
//   timeout        high while in LOSE when LOSE was reached by timeout
//   round_done     high for the single cycle spent in DONE
// -----------------------------------------------------------------------------
module guess_round_ctrl #(
  parameter  int MAX_ATTEMPTS  = 3,
  parameter  int TIMEOUT_TICKS = 8,
  parameter  int SCORE_W       = 4,
  localparam int ATT_W         = $clog2(MAX_ATTEMPTS + 1),
  localparam int TICK_W        = $clog2(TIMEOUT_TICKS)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               seg3,
  input  logic               button,
  input  logic               guess,
  input  logic               clr_score,
  output logic [2:0]         state,
  output logic [SCORE_W-1:0] score,
  output logic [ATT_W-1:0]   attempts_left,
  output logic               timeout,
  output logic               round_done
);

  // The encoding is the public interface to the renderer; do not reorder.
  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ARM   = 3'd1,
    S_CHECK = 3'd2,
    S_WIN   = 3'd3,
    S_LOSE  = 3'd4,
    S_DONE  = 3'd5,
    S_MISS  = 3'd6
  } state_t;

  state_t             r_state,    w_state_nxt;
  logic [SCORE_W-1:0] r_score,    w_score_nxt;
  logic [ATT_W-1:0]   r_attempts, w_attempts_nxt;
  logic [TICK_W-1:0]  r_tick_cnt, w_tick_cnt_nxt;
  logic               r_timeout,  w_timeout_nxt;
  logic               r_button_q;
  logic               w_btn_rise;

  // button_q is sampled every cycle so a level held through WIN/LOSE/MISS
  // never looks like a fresh press once ARM is re-entered.
  assign w_btn_rise = button & ~r_button_q;

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_IDLE;
      r_score    <= '0;
      r_attempts <= ATT_W'(MAX_ATTEMPTS);
      r_tick_cnt <= '0;
      r_timeout  <= 1'b0;
      r_button_q <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_score    <= w_score_nxt;
      r_attempts <= w_attempts_nxt;
      r_tick_cnt <= w_tick_cnt_nxt;
      r_timeout  <= w_timeout_nxt;
      r_button_q <= button;
    end
  end

  always_comb begin
    // NOTE: every next-value is defaulted to "hold" before the case so no
    // path through the logic can infer a latch.
    w_state_nxt    = r_state;
    w_score_nxt    = r_score;
    w_attempts_nxt = r_attempts;
    w_tick_cnt_nxt = r_tick_cnt;
    w_timeout_nxt  = r_timeout;

    case (r_state)
      S_ARM: begin
        // A press beats a coincident tick: the answer arrived in time.
        if (w_btn_rise) begin
          w_state_nxt    = S_CHECK;
          w_tick_cnt_nxt = '0;
        end else if (seg3) begin
          if (r_tick_cnt == TICK_W'(TIMEOUT_TICKS - 1)) begin
            w_state_nxt   = S_LOSE;
            w_timeout_nxt = 1'b1;
          end else begin
            w_tick_cnt_nxt = r_tick_cnt + TICK_W'(1);
          end
        end
      end

      S_CHECK: begin
        if (guess) begin
          w_state_nxt = S_WIN;
          if (r_score != '1) w_score_nxt = r_score + SCORE_W'(1);
        end else begin
          w_attempts_nxt = r_attempts - ATT_W'(1);
          w_timeout_nxt  = 1'b0;
          w_state_nxt    = (r_attempts == ATT_W'(1)) ? S_LOSE : S_MISS;
        end
      end

      S_MISS: begin
        if (seg3) begin
          w_state_nxt    = S_ARM;
          w_tick_cnt_nxt = '0;
        end
      end

      S_WIN, S_LOSE: begin
        if (seg3) w_state_nxt = S_DONE;
      end

      S_DONE: w_state_nxt = S_IDLE;

      // IDLE, and the unused code 7 which recovers exactly like IDLE.
      default: begin
        w_attempts_nxt = ATT_W'(MAX_ATTEMPTS);
        w_tick_cnt_nxt = '0;
        w_timeout_nxt  = 1'b0;
        w_state_nxt    = seg3 ? S_ARM : S_IDLE;
      end
    endcase

    // Clearing wins over a same-cycle increment from CHECK.
    if (clr_score) w_score_nxt = '0;
  end

  assign state         = r_state;
  assign score         = r_score;
  assign attempts_left = r_attempts;
  assign timeout       = r_timeout & (r_state == S_LOSE);
  assign round_done    = (r_state == S_DONE);

endmodule

// File: tb/tb_guess_round_ctrl.sv
// -----------------------------------------------------------------------------
// tb_guess_round_ctrl
// Self-checking bench for guess_round_ctrl with default parameters. Directed
// scenarios compare against constant expectations; a randomized run compares
// every cycle against a behavioural model of the round rules.
// -----------------------------------------------------------------------------
module tb_guess_round_ctrl;

  localparam int MAX_ATTEMPTS  = 3;
  localparam int TIMEOUT_TICKS = 8;
  localparam int SCORE_W       = 4;
  localparam int SCORE_MAX     = (1 << SCORE_W) - 1;

  logic               clk = 1'b0;
  logic               reset;
  logic               seg3;
  logic               button;
  logic               guess;
  logic               clr_score;
  logic [2:0]         state;
  logic [SCORE_W-1:0] score;
  logic [1:0]         attempts_left;
  logic               timeout;
  logic               round_done;

  int checks = 0;
  int errors = 0;

  // Behavioural model of one round: phase numbers follow the state codes
  // the renderer sees.
  int m_state, m_score, m_att, m_tick;
  bit m_to, m_bq;

  guess_round_ctrl #(
    .MAX_ATTEMPTS (MAX_ATTEMPTS),
    .TIMEOUT_TICKS(TIMEOUT_TICKS),
    .SCORE_W      (SCORE_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .seg3         (seg3),
    .button       (button),
    .guess        (guess),
    .clr_score    (clr_score),
    .state        (state),
    .score        (score),
    .attempts_left(attempts_left),
    .timeout      (timeout),
    .round_done   (round_done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_state = 0; m_score = 0; m_att = MAX_ATTEMPTS;
    m_tick = 0; m_to = 0; m_bq = 0;
  endtask

  task automatic model_step(input logic s, input logic b, input logic g, input logic c);
    bit rise;
    rise = b && !m_bq;
    m_bq = b;
    case (m_state)
      1: begin
        if (rise) begin
          m_state = 2; m_tick = 0;
        end else if (s) begin
          if (m_tick + 1 == TIMEOUT_TICKS) begin m_state = 4; m_to = 1; end
          else m_tick = m_tick + 1;
        end
      end
      2: begin
        if (g) begin
          m_state = 3;
          m_score = (m_score < SCORE_MAX) ? m_score + 1 : SCORE_MAX;
        end else begin
          m_att = m_att - 1;
          m_to = 0;
          m_state = (m_att == 0) ? 4 : 6;
        end
      end
      3, 4: if (s) m_state = 5;
      5: m_state = 0;
      6: if (s) begin m_state = 1; m_tick = 0; end
      default: begin
        m_att = MAX_ATTEMPTS; m_tick = 0; m_to = 0;
        m_state = s ? 1 : 0;
      end
    endcase
    if (c) m_score = 0;
  endtask

  // Drive one clock cycle worth of inputs, advance the model, and leave the
  // bench 1 time unit after the active edge where outputs are stable.
  task automatic step(input logic s, input logic b, input logic g, input logic c);
    seg3 = s; button = b; guess = g; clr_score = c;
    model_step(s, b, g, c);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    seg3 = 0; button = 0; guess = 0; clr_score = 0;
    reset = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  task automatic play_win(input logic clr);
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, clr);
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (state !== 3'd0 || score !== 4'd0 || attempts_left !== 2'd3 || timeout !== 1'b0 || round_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init state=%0d score=%0d att=%0d to=%0b done=%0b want 0/0/3/0/0",
               state, score, attempts_left, timeout, round_done);
    end
    play_win(1'b0);
    step(1, 0, 0, 0);
    checks++;
    if (state !== 3'd1 || score !== 4'd1) begin
      errors++;
      $display("FAIL reset_pre_arm state=%0d score=%0d want 1/1", state, score);
    end
    // Asynchronous assertion away from the clock edge.
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    checks++;
    if (state !== 3'd0 || score !== 4'd0 || attempts_left !== 2'd3 || timeout !== 1'b0 || round_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_async state=%0d score=%0d att=%0d to=%0b done=%0b want 0/0/3/0/0",
               state, score, attempts_left, timeout, round_done);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    step(1, 0, 0, 0);
    checks++;
    if (state !== 3'd1) begin
      errors++;
      $display("FAIL reset_release_arm state=%0d want 1", state);
    end
  endtask

  task automatic test_win();
    do_reset();
    step(1, 0, 0, 0);
    checks++;
    if (state !== 3'd1) begin errors++; $display("FAIL win_arm state=%0d want 1", state); end
    step(0, 1, 0, 0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL win_check state=%0d want 2", state); end
    step(0, 1, 1, 0);
    checks++;
    if (state !== 3'd3 || score !== 4'd1) begin
      errors++; $display("FAIL win_win state=%0d score=%0d want 3/1", state, score);
    end
    step(1, 0, 0, 0);
    checks++;
    if (state !== 3'd5 || round_done !== 1'b1) begin
      errors++; $display("FAIL win_done state=%0d done=%0b want 5/1", state, round_done);
    end
    step(0, 0, 0, 0);
    checks++;
    if (state !== 3'd0 || round_done !== 1'b0 || score !== 4'd1) begin
      errors++; $display("FAIL win_idle state=%0d done=%0b score=%0d want 0/0/1", state, round_done, score);
    end
  endtask

  task automatic test_attempts();
    logic [2:0] exp_st [3];
    logic [1:0] exp_att [3];
    exp_st  = '{3'd6, 3'd6, 3'd4};
    exp_att = '{2'd2, 2'd1, 2'd0};
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 0, 0, 0);
      step(0, 1, 0, 0);
      step(0, 1, 0, 0);
      checks++;
      if (state !== exp_st[i] || attempts_left !== exp_att[i] || timeout !== 1'b0) begin
        errors++;
        $display("FAIL attempt_%0d state=%0d att=%0d to=%0b want %0d/%0d/0",
                 i, state, attempts_left, timeout, exp_st[i], exp_att[i]);
      end
      if (i < 2) step(1, 1, 0, 0);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) begin
      step(1, 0, 0, 0);
      step(0, 0, 0, 0);
    end
    checks++;
    if (state !== 3'd1 || timeout !== 1'b0) begin
      errors++; $display("FAIL timeout_7ticks state=%0d to=%0b want 1/0", state, timeout);
    end
    step(1, 0, 0, 0);
    checks++;
    if (state !== 3'd4 || timeout !== 1'b1) begin
      errors++; $display("FAIL timeout_8ticks state=%0d to=%0b want 4/1", state, timeout);
    end
    // Tick and press together: the press wins, no timeout.
    do_reset();
    step(1, 0, 0, 0);
    for (int i = 0; i < TIMEOUT_TICKS - 1; i++) step(1, 0, 0, 0);
    step(1, 1, 0, 0);
    checks++;
    if (state !== 3'd2) begin
      errors++; $display("FAIL timeout_press_wins state=%0d want 2", state);
    end
  endtask

  task automatic test_button_held();
    do_reset();
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (state !== 3'd6) begin errors++; $display("FAIL held_miss state=%0d want 6", state); end
    step(1, 1, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(0, 1, 0, 0);
      checks++;
      if (state !== 3'd1) begin errors++; $display("FAIL held_no_check_%0d state=%0d want 1", i, state); end
    end
    step(0, 0, 0, 0);
    step(0, 1, 0, 0);
    checks++;
    if (state !== 3'd2) begin errors++; $display("FAIL held_rearm state=%0d want 2", state); end
  endtask

  task automatic test_score_sat();
    do_reset();
    for (int i = 0; i < SCORE_MAX; i++) play_win(1'b0);
    checks++;
    if (score !== 4'd15) begin errors++; $display("FAIL score_reach_max score=%0d want 15", score); end
    play_win(1'b0);
    checks++;
    if (score !== 4'd15) begin errors++; $display("FAIL score_saturate score=%0d want 15", score); end
    step(1, 0, 0, 0);
    step(0, 1, 0, 0);
    step(0, 1, 1, 1);
    checks++;
    if (state !== 3'd3 || score !== 4'd0) begin
      errors++; $display("FAIL score_clr_wins state=%0d score=%0d want 3/0", state, score);
    end
  endtask

  task automatic test_random();
    logic b;
    int exp_to;
    do_reset();
    b = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 2) == 0) b = ~b;
      step(($urandom_range(0, 3) == 0), b, 1'($urandom_range(0, 1)), ($urandom_range(0, 40) == 0));
      exp_to = (m_to && m_state == 4) ? 1 : 0;
      checks++;
      if (int'(state) != m_state || int'(score) != m_score || int'(attempts_left) != m_att ||
          int'(timeout) != exp_to || int'(round_done) != ((m_state == 5) ? 1 : 0)) begin
        errors++;
        $display("FAIL random_cycle_%0d got st=%0d sc=%0d att=%0d to=%0b done=%0b want st=%0d sc=%0d att=%0d to=%0d",
                 n, state, score, attempts_left, timeout, round_done, m_state, m_score, m_att, exp_to);
      end
    end
  endtask

  initial begin
    reset = 1'b0;
    seg3 = 0; button = 0; guess = 0; clr_score = 0;
    model_reset();
    #1;
    test_reset();
    test_win();
    test_attempts();
    test_timeout();
    test_button_held();
    test_score_sat();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
